// File: rtl/branch_unit.sv
// Branch-condition evaluator: signed/equality compare of two operands with a
// combinational result and a valid-qualified registered copy.
module branch_unit #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] in0,
  input  logic [WIDTH-1:0] in1,
  input  logic [1:0]       func,
  input  logic             in_valid,
  output logic             out,
  output logic             out_q,
  output logic             out_valid,
  output logic             eq_q,
  output logic             lt_q
);

  localparam logic [1:0] FUNC_EQ = 2'd0;
  localparam logic [1:0] FUNC_NE = 2'd1;
  localparam logic [1:0] FUNC_LE = 2'd2;
  localparam logic [1:0] FUNC_GT = 2'd3;

  logic eq;
  logic lt;
  logic le;

  logic out_d;
  logic eq_d;
  logic lt_d;
  logic valid_d;
  logic valid_q;

  // Operands are rs/rt register values, so ordering is two's-complement.
  always_comb begin
    eq = (in0 == in1);
    lt = ($signed(in0) < $signed(in1));
    le = eq | lt;
    out = 1'b0;
    case (func)
      FUNC_EQ: out = eq;
      FUNC_NE: out = ~eq;
      FUNC_LE: out = le;
      FUNC_GT: out = ~le;
      default: out = 1'b0;
    endcase
  end

  // Result flags hold when nothing is accepted; only the valid strobe drops.
  always_comb begin
    out_d   = out_q;
    eq_d    = eq_q;
    lt_d    = lt_q;
    valid_d = 1'b0;
    if (in_valid) begin
      out_d   = out;
      eq_d    = eq;
      lt_d    = lt;
      valid_d = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_q   <= 1'b0;
      eq_q    <= 1'b0;
      lt_q    <= 1'b0;
      valid_q <= 1'b0;
    end else begin
      out_q   <= out_d;
      eq_q    <= eq_d;
      lt_q    <= lt_d;
      valid_q <= valid_d;
    end
  end

  assign out_valid = valid_q;

endmodule

// File: tb/tb_branch_unit.sv
// Self-checking bench for branch_unit: directed boundary cases plus randomized
// traffic compared against an arithmetic reference model.
module tb_branch_unit;

  logic        clk;
  logic        rst_n;
  logic [31:0] in0;
  logic [31:0] in1;
  logic [1:0]  func;
  logic        in_valid;
  logic        out;
  logic        out_q;
  logic        out_valid;
  logic        eq_q;
  logic        lt_q;

  int n_tests = 0;
  int n_fail  = 0;

  bit m_out_q, m_eq_q, m_lt_q, m_valid;

  branch_unit #(.WIDTH(32)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .in0      (in0),
    .in1      (in1),
    .func     (func),
    .in_valid (in_valid),
    .out      (out),
    .out_q    (out_q),
    .out_valid(out_valid),
    .eq_q     (eq_q),
    .lt_q     (lt_q)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Reference: widen to 64-bit signed and use the sign of the difference.
  function automatic longint sx(input logic [31:0] v);
    longint r;
    r = v;
    if (r >= 64'sd2147483648) r = r - 64'sd4294967296;
    return r;
  endfunction

  function automatic bit ref_eq(input logic [31:0] a, input logic [31:0] b);
    return sx(a) == sx(b);
  endfunction

  function automatic bit ref_lt(input logic [31:0] a, input logic [31:0] b);
    return (sx(a) - sx(b)) < 0;
  endfunction

  function automatic bit ref_cond(input logic [31:0] a, input logic [31:0] b, input logic [1:0] f);
    longint d;
    d = sx(a) - sx(b);
    case (f)
      2'd0:    return d == 0;
      2'd1:    return d != 0;
      2'd2:    return d <= 0;
      default: return d > 0;
    endcase
  endfunction

  task automatic check_regs(input string tag);
    check({tag, ".out_valid"}, {31'd0, out_valid}, {31'd0, m_valid});
    check({tag, ".out_q"},     {31'd0, out_q},     {31'd0, m_out_q});
    check({tag, ".eq_q"},      {31'd0, eq_q},      {31'd0, m_eq_q});
    check({tag, ".lt_q"},      {31'd0, lt_q},      {31'd0, m_lt_q});
  endtask

  task automatic check_comb(input string tag);
    #1;
    check(tag, {31'd0, out}, {31'd0, ref_cond(in0, in1, func)});
  endtask

  // Advance one clock, updating the model from the inputs seen at the edge.
  task automatic step(input string tag);
    if (rst_n) begin
      if (in_valid) begin
        m_out_q = ref_cond(in0, in1, func);
        m_eq_q  = ref_eq(in0, in1);
        m_lt_q  = ref_lt(in0, in1);
        m_valid = 1'b1;
      end else begin
        m_valid = 1'b0;
      end
    end
    @(posedge clk);
    #1;
    check_regs(tag);
  endtask

  task automatic rand_operands();
    case ($urandom_range(0, 4))
      0: begin in0 = $urandom; in1 = in0; end
      1: begin in0 = $urandom; in1 = in0 ^ 32'h1; end
      2: begin
        if ($urandom_range(0, 1) == 1) begin in0 = 32'h8000_0000; in1 = 32'h7FFF_FFFF; end
        else begin in0 = 32'h7FFF_FFFF; in1 = 32'h8000_0000; end
      end
      3: begin in0 = $urandom; in1 = $urandom; end
      default: begin
        in0 = 32'($signed($urandom_range(0, 6)) - 3);
        in1 = 32'($signed($urandom_range(0, 6)) - 3);
      end
    endcase
  endtask

  initial begin
    logic [31:0] exp_seq;
    rst_n    = 1'b0;
    in0      = 32'h0;
    in1      = 32'h0;
    func     = 2'd0;
    in_valid = 1'b1;
    m_out_q = 0; m_eq_q = 0; m_lt_q = 0; m_valid = 0;

    #2;
    check_regs("reset_initial");
    step("reset_clocked");
    step("reset_clocked2");

    // Combinational sweeps with no clock dependency, still inside reset.
    in0 = 32'hAFAF_AFAF; in1 = 32'hAFAF_AFAF;
    exp_seq = 32'b0101;
    for (int f = 0; f < 4; f++) begin
      func = 2'(f);
      #1;
      check($sformatf("eq_sweep_f%0d", f), {31'd0, out}, {31'd0, exp_seq[f]});
    end
    in1 = 32'hAFAF_AFAE;
    exp_seq = 32'b1010;
    for (int f = 0; f < 4; f++) begin
      func = 2'(f);
      #1;
      check($sformatf("lsb_sweep_f%0d", f), {31'd0, out}, {31'd0, exp_seq[f]});
    end

    @(negedge clk);
    rst_n = 1'b1;
    in_valid = 1'b0;
    step("release_idle");

    in0 = 32'h8000_0000; in1 = 32'h7FFF_FFFF;
    func = 2'd2; #1; check("sign_le", {31'd0, out}, 32'd1);
    func = 2'd3; #1; check("sign_gt", {31'd0, out}, 32'd0);
    in_valid = 1'b1;
    step("sign_reg");
    check("sign_lt_q", {31'd0, lt_q}, 32'd1);
    check("sign_eq_q", {31'd0, eq_q}, 32'd0);

    in0 = 32'h0; in1 = 32'hFFFF_FFFF; func = 2'd3;
    #1; check("zero_gt_neg1", {31'd0, out}, 32'd1);

    // Pipeline: four EQ vectors back-to-back, then idle.
    in0 = 32'hAFAF_AFAF; in1 = 32'hAFAF_AFAF; in_valid = 1'b1;
    exp_seq = 32'b0101;
    for (int f = 0; f < 4; f++) begin
      func = 2'(f);
      step($sformatf("pipe_%0d", f));
      check($sformatf("pipe_out_q_%0d", f), {31'd0, out_q}, {31'd0, exp_seq[f]});
      check($sformatf("pipe_valid_%0d", f), {31'd0, out_valid}, 32'd1);
    end
    in_valid = 1'b0;
    func = 2'd0;
    step("pipe_idle");
    check("pipe_idle_out_q", {31'd0, out_q}, 32'd0);
    step("pipe_idle2");

    // Async reset between edges with a live result.
    in_valid = 1'b1; func = 2'd0;
    step("pre_reset");
    check("pre_reset_out_q", {31'd0, out_q}, 32'd1);
    #3;
    rst_n = 1'b0;
    m_out_q = 0; m_eq_q = 0; m_lt_q = 0; m_valid = 0;
    #1;
    check_regs("async_reset");
    in1 = 32'h1234_5678;
    check_comb("reset_comb_track");
    @(negedge clk);
    rst_n = 1'b1;
    in_valid = 1'b0;
    step("post_reset_idle");

    // Randomized traffic.
    for (int i = 0; i < 300; i++) begin
      rand_operands();
      func = 2'($urandom_range(0, 3));
      in_valid = ($urandom_range(0, 3) != 0);
      check_comb("rand_comb");
      step("rand");
      if ($urandom_range(0, 3) == 0) begin
        func = 2'($urandom_range(0, 3));
        check_comb("rand_func_only");
      end
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/branch_unit.md
Name: branch_unit

Overview:
- Branch-condition evaluator for the MIPS datapath; compares two register operands and reports whether the selected branch condition holds.
- Supports four conditions: EQ, NE, LE, GT, selected by a 2-bit function code.
- Provides a combinational result for same-cycle branch resolution.
- Provides a registered, valid-qualified copy for the pipeline's branch-resolve stage.

Parameters:
- WIDTH, 32, operand width in bits.

Ports:
- clk  input  1  system clock; all registered state updates on the rising edge.
- rst_n  input  1  asynchronous active-low reset.
- in0  input  WIDTH  first operand (rs).
- in1  input  WIDTH  second operand (rt).
- func  input  2  condition select: 0=EQ, 1=NE, 2=LE, 3=GT.
- in_valid  input  1  qualifies in0/in1/func for capture into the registered stage.
- out  output  1  combinational condition result for the current inputs.
- out_q  output  1  registered condition result.
- out_valid  output  1  high for one cycle after each accepted in_valid.
- eq_q  output  1  registered "in0 == in1" flag.
- lt_q  output  1  registered "in0 < in1" (signed) flag.

Behaviour:
- Reset and clock:
  - The block uses one clock and an asynchronous, active-low reset.
  - While rst_n = 0: out_q = 0, out_valid = 0, eq_q = 0, lt_q = 0, regardless of clk.
  - Release of rst_n is taken on the next rising clk edge.
- Comparison semantics:
  - eq = (in0 == in1), all WIDTH bits.
  - lt = signed two's-complement in0 < in1.
  - le = eq | lt.
  - gt = ~le.
- Function mapping:
  - func=0 → eq.
  - func=1 → ~eq.
  - func=2 → le.
  - func=3 → gt.
  - All four codes are defined; there is no illegal encoding.
- out is purely combinational from in0, in1 and func:
  - No clock or reset dependency.
  - Settles within the same time step as an input change.
  - out is valid even while rst_n = 0.
- Registered stage:
  - On a rising clk edge with rst_n = 1 and in_valid = 1: out_q ← out, eq_q ← eq, lt_q ← lt, out_valid ← 1.
  - With in_valid = 0: out_valid ← 0; out_q, eq_q and lt_q hold their previous values.
  - Latency: 1 cycle from accepted input to out_q / out_valid.
  - Back-to-back in_valid produces back-to-back out_valid with no bubbles; there is no backpressure.
- Boundary conditions:
  - Sign boundary: in0 = 0x80000000 (most negative), in1 = 0x7FFFFFFF gives lt = 1, so LE = 1 and GT = 0. Unsigned interpretation is forbidden.
  - Equal operands: EQ = 1, NE = 0, LE = 1, GT = 0.
  - Operands differing only in the LSB are distinguished by every condition.
  - Asserting reset mid-stream clears out_valid and the registered flags immediately; an in-flight result is dropped.
  - A func change without in_valid affects out only.
- Width: all comparisons use the full WIDTH bits; no zero- or sign-extension of the inputs.

Test Plan:
- in0 = in1 = 0xAFAFAFAF, sweep func 0..3 with a settle delay and no clock → out = 1, 0, 1, 0.
- in0 = 0xAFAFAFAF, in1 = 0xAFAFAFAE, sweep func 0..3 → out = 0, 1, 0, 1.
- in0 = 0x80000000, in1 = 0x7FFFFFFF:
  - func = 2 → out = 1.
  - func = 3 → out = 0.
  - With in_valid = 1 and one clock: lt_q = 1, eq_q = 0.
- Pipeline: apply the four EQ-operand vectors on consecutive cycles with in_valid = 1 → out_valid high for 4 consecutive cycles, out_q = 1, 0, 1, 0 each one cycle late; then in_valid = 0 → out_valid = 0 and out_q holds 0.
- Async reset: drive rst_n low between clock edges while out_valid = 1 and out_q = 1 → out_valid, out_q, eq_q and lt_q go to 0 immediately; out still tracks the inputs combinationally.
- in0 = 0, in1 = 0xFFFFFFFF (−1), func = 3 → out = 1 (signed GT).
